// File: rtl/operand_dispatch.sv
// operand_dispatch
// Purpose: single-entry dispatch buffer that takes one operation (opcode plus
// two operands) from upstream and presents it to exactly one functional-unit
// channel selected by the opcode. The held operation is replaced in the same
// cycle it issues, so back-to-back traffic flows without bubbles.
//
// Optional feature macro: DISPATCH_CNT_EN
//   When defined, adds the dispatch_cnt output, a 16-bit wrapping count of
//   completed channel transfers. When undefined, the port and its logic are
//   absent.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   op_opcode    in   [SEL_LINE]   channel select of the offered operation
//   rs1_reg_val  in   [N]          first operand
//   rs2_reg_val  in   [N]          second operand
//   in_valid     in   upstream offers an operation
//   in_ready     out  operation is accepted this cycle when in_valid is high
//   ch_valid     out  [NUM_CH]     one-hot, held channel has a valid operation
//   ch_ready     in   [NUM_CH]     channel consumes its operation this cycle
//   ch_rs1       out  [NUM_CH*N]   per-channel rs1, channel k at [k*N +: N]
//   ch_rs2       out  [NUM_CH*N]   per-channel rs2, same packing
//   illegal_op   out  one-cycle pulse after an out-of-range opcode is accepted
//   dispatch_cnt out  [16]         completed transfers (DISPATCH_CNT_EN only)
module operand_dispatch #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int NUM_CH   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_LINE-1:0]   op_opcode,
  input  logic [N-1:0]          rs1_reg_val,
  input  logic [N-1:0]          rs2_reg_val,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_CH-1:0]     ch_valid,
  input  logic [NUM_CH-1:0]     ch_ready,
  output logic [NUM_CH*N-1:0]   ch_rs1,
  output logic [NUM_CH*N-1:0]   ch_rs2,
`ifdef DISPATCH_CNT_EN
  output logic                  illegal_op,
  output logic [15:0]           dispatch_cnt
`else
  output logic                  illegal_op
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  // Channel count widened by one bit so that NUM_CH == 2**SEL_LINE still
  // compares correctly against every opcode value.
  localparam logic [SEL_LINE:0] NUM_CH_W = (SEL_LINE+1)'(NUM_CH);

  logic [0:0]          r_state;
  logic [SEL_LINE-1:0] r_opcode;
  logic [N-1:0]        r_rs1;
  logic [N-1:0]        r_rs2;
  logic                r_illegal;

  logic [NUM_CH-1:0]   w_sel;
  logic                w_held_ready;
  logic                w_legal;
  logic                w_accept;
  logic                w_issue;

  // One-hot decode of the held opcode; all zero while empty. Only the held
  // channel's ready bit is looked at, so other channels' ready is ignored.
  always_comb begin
    w_sel        = '0;
    w_held_ready = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sel[k] = (r_state == ST_HOLD) && (r_opcode == SEL_LINE'(k));
      if (w_sel[k] && ch_ready[k]) begin
        w_held_ready = 1'b1;
      end
    end
  end

  // A full buffer can still accept when its occupant leaves this same cycle.
  assign w_legal  = ({1'b0, op_opcode} < NUM_CH_W);
  assign in_ready = (r_state == ST_EMPTY) || w_held_ready;
  assign w_accept = in_valid && in_ready;
  assign w_issue  = (r_state == ST_HOLD) && w_held_ready;

  // Holding register and FSM. A legal accept always (re)loads the entry,
  // covering both the empty case and the same-cycle replace. An illegal
  // accept stores nothing, so only a pending issue can move the state.
  // Cleared entries are zeroed so nothing stale lingers in the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_opcode  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_state  <= ST_HOLD;
        r_opcode <= op_opcode;
        r_rs1    <= rs1_reg_val;
        r_rs2    <= rs2_reg_val;
      end else if (w_issue) begin
        r_state  <= ST_EMPTY;
        r_opcode <= '0;
        r_rs1    <= '0;
        r_rs2    <= '0;
      end
    end
  end

  // Fan the registered operands out to the selected channel only; every
  // other channel sees zero.
  always_comb begin
    ch_rs1 = '0;
    ch_rs2 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel[k]) begin
        ch_rs1[k*N +: N] = r_rs1;
        ch_rs2[k*N +: N] = r_rs2;
      end
    end
  end

  assign ch_valid   = w_sel;
  assign illegal_op = r_illegal;

`ifdef DISPATCH_CNT_EN
  logic [15:0] r_cnt;

  // Counts real transfers only; illegal opcodes never reach a channel.
  // Natural 16-bit overflow provides the wrap to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign dispatch_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_operand_dispatch.sv
// tb_operand_dispatch
// Purpose: directed self-checking bench for operand_dispatch with the default
// parameters (N=16, SEL_LINE=4, NUM_CH=7). Counter checks are compiled in
// only when DISPATCH_CNT_EN is defined, matching the design's port list.
module tb_operand_dispatch;

  localparam int N        = 16;
  localparam int SEL_LINE = 4;
  localparam int NUM_CH   = 7;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [SEL_LINE-1:0] op_opcode = '0;
  logic [N-1:0]        rs1_reg_val = '0;
  logic [N-1:0]        rs2_reg_val = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [NUM_CH-1:0]   ch_valid;
  logic [NUM_CH-1:0]   ch_ready = '0;
  logic [NUM_CH*N-1:0] ch_rs1;
  logic [NUM_CH*N-1:0] ch_rs2;
  logic                illegal_op;
`ifdef DISPATCH_CNT_EN
  logic [15:0]         dispatch_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  operand_dispatch #(.N(N), .SEL_LINE(SEL_LINE), .NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_opcode    (op_opcode),
    .rs1_reg_val  (rs1_reg_val),
    .rs2_reg_val  (rs2_reg_val),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_rs1       (ch_rs1),
    .ch_rs2       (ch_rs2),
`ifdef DISPATCH_CNT_EN
    .illegal_op   (illegal_op),
    .dispatch_cnt (dispatch_cnt)
`else
    .illegal_op   (illegal_op)
`endif
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation offer onto the upstream inputs.
  task automatic applyStimulus(input logic v, input logic [SEL_LINE-1:0] op,
                               input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [NUM_CH-1:0] rdy);
    in_valid    = v;
    op_opcode   = op;
    rs1_reg_val = a;
    rs2_reg_val = b;
    ch_ready    = rdy;
  endtask

  // Advance one clock and settle 1 unit past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Place a 16-bit value at channel k of a packed bus, zeros elsewhere.
  function automatic logic [127:0] chBus(input int k, input logic [N-1:0] v);
    logic [127:0] r;
    r = '0;
    r[k*N +: N] = v;
    return r;
  endfunction

  initial begin
    // Asynchronous reset: outputs must clear with no clock edge.
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_ch_valid", 128'(ch_valid), 128'h0);
    checkOutput("rst_ch_rs1", 128'(ch_rs1), 128'h0);
    checkOutput("rst_illegal", 128'(illegal_op), 128'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", 128'(in_ready), 128'h1);
`ifdef DISPATCH_CNT_EN
    checkOutput("rst_cnt", 128'(dispatch_cnt), 128'h0);
`endif

    // Single op to channel 0, downstream not ready.
    applyStimulus(1'b1, 4'd0, 16'h1234, 16'h0005, 7'b0000000);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b0000000);
    checkOutput("op0_ch_valid", 128'(ch_valid), 128'h01);
    checkOutput("op0_ch_rs1", 128'(ch_rs1), chBus(0, 16'h1234));
    checkOutput("op0_ch_rs2", 128'(ch_rs2), chBus(0, 16'h0005));
    checkOutput("op0_in_ready_stall", 128'(in_ready), 128'h0);
    ch_ready = 7'b0000001;
    #1;
    checkOutput("op0_in_ready_issue", 128'(in_ready), 128'h1);
    tick();
    checkOutput("op0_drained", 128'(ch_valid), 128'h0);
    checkOutput("op0_rs1_cleared", 128'(ch_rs1), 128'h0);

    // Stall on channel 3 for 5 cycles; a competing offer and the ready
    // bits of other channels must not disturb it.
    applyStimulus(1'b1, 4'd3, 16'hAAAA, 16'h5555, 7'b0000000);
    tick();
    applyStimulus(1'b1, 4'd5, 16'hFFFF, 16'hEEEE, 7'b1110111);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ch_valid", 128'(ch_valid), 128'h08);
      checkOutput("stall_ch_rs1", 128'(ch_rs1), chBus(3, 16'hAAAA));
      checkOutput("stall_ch_rs2", 128'(ch_rs2), chBus(3, 16'h5555));
      checkOutput("stall_in_ready", 128'(in_ready), 128'h0);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b0001000);
    tick();
    checkOutput("stall_released", 128'(ch_valid), 128'h0);
`ifdef DISPATCH_CNT_EN
    checkOutput("cnt_after_two", 128'(dispatch_cnt), 128'd2);
`endif

    // Back-to-back opcodes 1, 2, 6 with every channel ready.
    applyStimulus(1'b1, 4'd1, 16'h0001, 16'h0101, 7'b1111111);
    tick();
    checkOutput("b2b_ch_valid_1", 128'(ch_valid), 128'h02);
    checkOutput("b2b_in_ready_1", 128'(in_ready), 128'h1);
    applyStimulus(1'b1, 4'd2, 16'h0002, 16'h0202, 7'b1111111);
    tick();
    checkOutput("b2b_ch_valid_2", 128'(ch_valid), 128'h04);
    checkOutput("b2b_ch_rs1_2", 128'(ch_rs1), chBus(2, 16'h0002));
    applyStimulus(1'b1, 4'd6, 16'h0006, 16'h0606, 7'b1111111);
    tick();
    checkOutput("b2b_ch_valid_6", 128'(ch_valid), 128'h40);
    checkOutput("b2b_ch_rs2_6", 128'(ch_rs2), chBus(6, 16'h0606));
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b1111111);
    tick();
    checkOutput("b2b_drained", 128'(ch_valid), 128'h0);
`ifdef DISPATCH_CNT_EN
    checkOutput("cnt_after_b2b", 128'(dispatch_cnt), 128'd5);
`endif

    // Illegal opcodes 7 (first out of range) then 9, from empty.
    applyStimulus(1'b1, 4'd7, 16'h7777, 16'h7777, 7'b1111111);
    tick();
    checkOutput("ill7_pulse", 128'(illegal_op), 128'h1);
    checkOutput("ill7_ch_valid", 128'(ch_valid), 128'h0);
    applyStimulus(1'b1, 4'd9, 16'h9999, 16'h9999, 7'b1111111);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b0000000);
    checkOutput("ill9_pulse", 128'(illegal_op), 128'h1);
    checkOutput("ill9_ch_valid", 128'(ch_valid), 128'h0);
    tick();
    checkOutput("ill_pulse_end", 128'(illegal_op), 128'h0);
    checkOutput("ill_in_ready", 128'(in_ready), 128'h1);
`ifdef DISPATCH_CNT_EN
    checkOutput("cnt_after_ill", 128'(dispatch_cnt), 128'd5);
`endif

    // Reset while holding opcode 4: cleared immediately, never issued.
    applyStimulus(1'b1, 4'd4, 16'h4444, 16'h4040, 7'b0000000);
    tick();
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b0000000);
    checkOutput("mid_hold_ch_valid", 128'(ch_valid), 128'h10);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_ch_valid", 128'(ch_valid), 128'h0);
    checkOutput("mid_rst_ch_rs1", 128'(ch_rs1), 128'h0);
    ch_ready = 7'b1111111;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_ch_valid", 128'(ch_valid), 128'h0);
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'h1);
`ifdef DISPATCH_CNT_EN
    checkOutput("post_rst_cnt", 128'(dispatch_cnt), 128'h0);

    // Counter wrap: first edge only accepts, each later edge issues and
    // reloads, so 65536 edges yield 65535 issues; one more drains it.
    applyStimulus(1'b1, 4'd0, 16'h0001, 16'h0001, 7'b1111111);
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("cnt_ffff", 128'(dispatch_cnt), 128'hFFFF);
    applyStimulus(1'b0, 4'd0, 16'h0000, 16'h0000, 7'b1111111);
    tick();
    checkOutput("cnt_wrap", 128'(dispatch_cnt), 128'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
